// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 Set-2 scan-code byte sequences (E0/F0 prefixes, E1 Pause) into single key
// events held in a one-entry output register. The receiver FIFO is popped only when a byte can be taken.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_pause,
  output logic [7:0] timeout_cnt,
  input  logic       clr_stat,
  output logic [2:0] dbg_state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_E0     = 3'd1,
    ST_F0     = 3'd2,
    ST_E0F0   = 3'd3,
    ST_PAUSE  = 3'd4
  } state_e;

  state_e        state_q;
  logic [2:0]    skip_q;
  logic [TW-1:0] idle_q;
  logic [7:0]    tcnt_q;
  logic          evt_valid_q;
  logic [7:0]    evt_code_q;
  logic          evt_ext_q;
  logic          evt_brk_q;
  logic          evt_pause_q;
  logic          take;

  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Handshakes: the receiver side pops a byte on any rising edge where kbd_nextdata_n=0 and
  // kbd_ready=1; the event side transfers on any rising edge where evt_valid=1 and evt_ready=1,
  // with evt_* fields held stable while evt_valid=1 and not transferred.
  assign take           = kbd_ready & ~evt_valid_q;
  assign kbd_nextdata_n = ~(take & clrn);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      skip_q      <= 3'd0;
      idle_q      <= '0;
      tcnt_q      <= 8'h00;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      evt_pause_q <= 1'b0;
    end else begin
      if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end

      if (take) begin
        idle_q <= '0;
        unique case (state_q)
          ST_IDLE: begin
            if (kbd_data == 8'hE0) begin
              state_q <= ST_E0;
            end else if (kbd_data == 8'hF0) begin
              state_q <= ST_F0;
            end else if (kbd_data == 8'hE1) begin
              state_q <= ST_PAUSE;
              skip_q  <= 3'd7;
            end else if (!is_filler(kbd_data)) begin
              evt_valid_q <= 1'b1;
              evt_code_q  <= kbd_data;
              evt_ext_q   <= 1'b0;
              evt_brk_q   <= 1'b0;
              evt_pause_q <= 1'b0;
            end
          end
          ST_E0: begin
            if (kbd_data == 8'hF0) begin
              state_q <= ST_E0F0;
            end else if (kbd_data != 8'hE0) begin
              state_q     <= ST_IDLE;
              evt_valid_q <= 1'b1;
              evt_code_q  <= kbd_data;
              evt_ext_q   <= 1'b1;
              evt_brk_q   <= 1'b0;
              evt_pause_q <= 1'b0;
            end
          end
          ST_F0: begin
            if (kbd_data != 8'hF0) begin
              state_q     <= ST_IDLE;
              evt_valid_q <= 1'b1;
              evt_code_q  <= kbd_data;
              evt_ext_q   <= 1'b0;
              evt_brk_q   <= 1'b1;
              evt_pause_q <= 1'b0;
            end
          end
          ST_E0F0: begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b1;
            evt_code_q  <= kbd_data;
            evt_ext_q   <= 1'b1;
            evt_brk_q   <= 1'b1;
            evt_pause_q <= 1'b0;
          end
          ST_PAUSE: begin
            // The seven bytes after E1 are swallowed blindly; the last one reports Pause.
            if (skip_q == 3'd1) begin
              state_q     <= ST_IDLE;
              skip_q      <= 3'd0;
              evt_valid_q <= 1'b1;
              evt_code_q  <= 8'h77;
              evt_ext_q   <= 1'b0;
              evt_brk_q   <= 1'b0;
              evt_pause_q <= 1'b1;
            end else begin
              skip_q <= skip_q - 3'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (idle_q == IDLE_LAST) begin
          state_q <= ST_IDLE;
          idle_q  <= '0;
          if (tcnt_q != 8'hFF) begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end else begin
          idle_q <= idle_q + TW'(1);
        end
      end else begin
        idle_q <= '0;
      end

      if (clr_stat) begin
        tcnt_q <= 8'h00;
      end
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_ext     = evt_ext_q;
  assign evt_break   = evt_brk_q;
  assign evt_pause   = evt_pause_q;
  assign timeout_cnt = tcnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus random byte streams checked
// cycle by cycle against a sequence-buffer model of the scan-code rules.
module tb_ps2_scancode_decoder;

  localparam int TO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_pause;
  logic [7:0] timeout_cnt;
  logic       clr_stat;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_pause      (evt_pause),
    .timeout_cnt    (timeout_cnt),
    .clr_stat       (clr_stat),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  int dut_pops = 0;
  int dut_evts = 0;

  logic [7:0]  src_q[$];   // receiver FIFO contents
  logic [7:0]  m_seq[$];   // bytes of the partial sequence so far
  logic [10:0] exp_q[$];   // {pause, break, ext, code} of events not yet transferred
  logic        m_valid;
  logic [7:0]  m_code;
  logic        m_ext, m_brk, m_pause;
  int          m_tcnt;
  int          m_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit filler(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_code = 8'h00; m_ext = 0; m_brk = 0; m_pause = 0;
    m_tcnt = 0; m_idle = 0;
    m_seq.delete(); exp_q.delete(); src_q.delete();
  endtask

  task automatic model_emit(input logic [7:0] c, input bit e, input bit br, input bit p);
    m_valid = 1; m_code = c; m_ext = e; m_brk = br; m_pause = p;
    exp_q.push_back({p, br, e, c});
  endtask

  // Decide from the whole buffered sequence whether it now forms a complete key event.
  task automatic model_byte(input logic [7:0] b);
    bit ext, f0seen;
    m_seq.push_back(b);
    if (m_seq[0] == 8'hE1) begin
      if (m_seq.size() == 8) begin
        model_emit(8'h77, 0, 0, 1);
        m_seq.delete();
      end
      return;
    end
    if (m_seq.size() == 1 && filler(b)) begin
      m_seq.delete();
      return;
    end
    ext = (m_seq[0] == 8'hE0);
    f0seen = 0;
    for (int i = 0; i < m_seq.size() - 1; i++)
      if (m_seq[i] == 8'hF0) f0seen = 1;
    if (b == 8'hE0 && !f0seen) return;
    if (b == 8'hF0 && !(f0seen && ext)) return;
    model_emit(b, ext, f0seen, 0);
    m_seq.delete();
  endtask

  // ---------------- driver: one clock cycle, entered and left just after a falling edge ----------------
  task automatic cycle();
    bit pop_e;
    logic [7:0] b;
    kbd_ready = (src_q.size() != 0);
    kbd_data  = kbd_ready ? src_q[0] : 8'h00;
    #1;
    pop_e = kbd_ready && !m_valid;
    check("nextdata_n", kbd_nextdata_n, !pop_e);
    if (!kbd_nextdata_n && kbd_ready) dut_pops++;
    if (evt_valid && evt_ready) begin
      dut_evts++;
      if (exp_q.size() == 0) check("spurious_evt", {evt_pause, evt_break, evt_ext, evt_code}, 32'hFFFF_FFFF);
      else check("evt_fields", {evt_pause, evt_break, evt_ext, evt_code}, exp_q.pop_front());
    end
    if (m_valid && evt_ready) m_valid = 0;
    if (pop_e) begin
      b = src_q.pop_front();
      m_idle = 0;
      model_byte(b);
    end else if (m_seq.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_seq.delete();
        m_idle = 0;
        if (m_tcnt < 255) m_tcnt++;
      end
    end else begin
      m_idle = 0;
    end
    if (clr_stat) m_tcnt = 0;
    @(negedge clk);
    #1;
    check("evt_valid", evt_valid, m_valid);
    check("evt_code", evt_code, m_code);
    check("evt_ext", evt_ext, m_ext);
    check("evt_break", evt_break, m_brk);
    check("evt_pause", evt_pause, m_pause);
    check("timeout_cnt", timeout_cnt, m_tcnt);
  endtask

  task automatic feed(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || m_valid) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("drain_budget", n, 0);
  endtask

  task automatic wait_idle_last(input int budget);
    int n = 0;
    while (m_idle != TO - 1 && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("idle_budget", m_idle, TO - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_code"}, evt_code, 0);
    check({tag, "_ext"}, evt_ext, 0);
    check({tag, "_break"}, evt_break, 0);
    check({tag, "_pause"}, evt_pause, 0);
    check({tag, "_tcnt"}, timeout_cnt, 0);
    check({tag, "_nextdata_n"}, kbd_nextdata_n, 1);
  endtask

  // Asserts clrn mid-cycle, checks outputs immediately, then releases after two edges.
  task automatic async_reset(input string tag);
    kbd_ready = 1'b1;
    kbd_data  = 8'h1C;
    #2;
    clrn = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    #1;
    clrn = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
      3: return ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int p0, e0;
    clrn = 1'b0; kbd_ready = 1'b1; kbd_data = 8'h1C; evt_ready = 1'b0; clr_stat = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    #1;
    clrn = 1'b1;

    // single make
    evt_ready = 1'b1;
    p0 = dut_pops; e0 = dut_evts;
    feed(8'h1C);
    drain(20);
    check("make_pops", dut_pops - p0, 1);
    check("make_evts", dut_evts - e0, 1);

    // break / extended / extended break
    p0 = dut_pops; e0 = dut_evts;
    feed(8'hF0); feed(8'h1C); feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75);
    drain(40);
    check("brkext_pops", dut_pops - p0, 7);
    check("brkext_evts", dut_evts - e0, 3);

    // fillers then Pause
    p0 = dut_pops; e0 = dut_evts;
    feed(8'hAA); feed(8'hFA);
    feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1); feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77);
    drain(40);
    check("pause_pops", dut_pops - p0, 10);
    check("pause_evts", dut_evts - e0, 1);

    // backpressure
    evt_ready = 1'b0;
    p0 = dut_pops; e0 = dut_evts;
    feed(8'h1C); feed(8'h32);
    repeat (6) cycle();
    check("bp_valid", evt_valid, 1);
    check("bp_code", evt_code, 8'h1C);
    check("bp_pops", dut_pops - p0, 1);
    evt_ready = 1'b1;
    drain(20);
    check("bp_evts", dut_evts - e0, 2);
    check("bp_last_code", evt_code, 8'h32);

    // timeout after a lone E0
    feed(8'hE0);
    repeat (21) cycle();
    check("to_count", timeout_cnt, 1);
    feed(8'h1C);
    drain(20);
    check("to_next_ext", evt_ext, 0);
    clr_stat = 1'b1; cycle(); clr_stat = 1'b0;
    check("to_clr", timeout_cnt, 0);

    // byte arriving on the timeout cycle wins; clear on the timeout cycle wins
    feed(8'hF0);
    cycle();
    wait_idle_last(40);
    feed(8'h2B);
    drain(20);
    check("to_byte_wins_tcnt", timeout_cnt, 0);
    check("to_byte_wins_brk", evt_break, 1);
    feed(8'hE0); cycle();
    repeat (20) cycle();
    feed(8'hE0); cycle();
    wait_idle_last(40);
    clr_stat = 1'b1; cycle(); clr_stat = 1'b0;
    check("to_clr_wins", timeout_cnt, 0);

    // saturation at FF
    for (int i = 0; i < 260; i++) begin
      feed(8'hE0);
      repeat (18) cycle();
    end
    check("to_saturate", timeout_cnt, 8'hFF);

    // async reset with a pending event, then mid-sequence after F0
    evt_ready = 1'b0;
    feed(8'hF0); feed(8'h1C);
    repeat (4) cycle();
    check("pre_rst_valid", evt_valid, 1);
    async_reset("arst_evt");
    evt_ready = 1'b1;
    feed(8'hF0);
    repeat (2) cycle();
    async_reset("arst_f0");
    feed(8'h1C);
    drain(20);
    check("post_rst_code", evt_code, 8'h1C);
    check("post_rst_break", evt_break, 0);
    check("post_rst_ext", evt_ext, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_stat  = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 149) == 0) begin
        repeat (20) cycle();
      end else begin
        if (src_q.size() < 4 && $urandom_range(0, 2) == 0) feed(rand_byte());
        cycle();
      end
    end
    clr_stat  = 1'b0;
    evt_ready = 1'b1;
    drain(200);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
